// File: rtl/vga_console_pkg.sv
// vga_console_pkg: shared constants, state type and address helpers for the
// VGA text console.
//   COLS / ROWS / CLEAR_CHAR : default screen geometry and clear byte
//   ASCII_*                  : control codes the console interprets
//   console_state_e          : console controller states
//   phys_row()               : logical row -> physical buffer row, given a scroll base
//   make_addr()              : {row, col} text buffer address
package vga_console_pkg;

  localparam int         COLS       = 64;
  localparam int         ROWS       = 30;
  localparam logic [7:0] CLEAR_CHAR = 8'h00;

  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] ASCII_TAB  = 8'h09;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] PRINT_LO   = 8'h20;
  localparam logic [7:0] PRINT_HI   = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    CLR_ROW,
    CLR_ALL
  } console_state_e;

  // base and row are both < rows, so their sum is < 2*rows and a single
  // compare-and-subtract is enough to wrap it.
  function automatic logic [4:0] phys_row(input logic [4:0] base,
                                          input logic [4:0] row,
                                          input logic [5:0] rows);
    logic [5:0] sum;
    sum = {1'b0, base} + {1'b0, row};
    if (sum >= rows) sum = sum - rows;
    return sum[4:0];
  endfunction

  function automatic logic [10:0] make_addr(input logic [4:0] row,
                                            input logic [5:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vga_text_console_if.sv
// vga_text_console_if: byte-stream valid/ready handshake into the console.
//   ch_valid : source has a byte on ch_data
//   ch_data  : ASCII byte
//   ch_ready : console accepts the byte this cycle
// master = byte source, slave = console.
interface vga_text_console_if;

  logic       ch_valid;
  logic [7:0] ch_data;
  logic       ch_ready;

  modport master (output ch_valid, output ch_data, input  ch_ready);
  modport slave  (input  ch_valid, input  ch_data, output ch_ready);

endinterface

// File: rtl/vga_console_fill.sv
// vga_console_fill: address sweep engine for the screen clear operations.
//   VGA_CLK   : clock (posedge)
//   reset     : asynchronous, active-low
//   start     : begin a sweep next cycle (restarts an ongoing one)
//   start_row : physical row to sweep in row-only mode
//   full      : 1 = whole screen row-major from (0,0), 0 = start_row only
//   addr      : address to write this cycle while busy
//   busy      : addr is valid
//   done      : this cycle's addr is the last of the sweep
// Leaves reset already busy in full mode at (0,0), so the power-on screen
// clear runs without a start pulse.
module vga_console_fill #(
  parameter int ROWS = vga_console_pkg::ROWS
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  start_row,
  input  logic        full,
  output logic [10:0] addr,
  output logic        busy,
  output logic        done
);
  import vga_console_pkg::*;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);

  logic       busy_q, busy_d;
  logic       full_q, full_d;
  logic [4:0] row_q,  row_d;
  logic [5:0] col_q,  col_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b1;
      full_q <= 1'b1;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      busy_q <= busy_d;
      full_q <= full_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is assigned a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    busy_d = busy_q;
    full_d = full_q;
    row_d  = row_q;
    col_d  = col_q;
    done   = busy_q && (col_q == LAST_COL) && (!full_q || (row_q == LAST_ROW));

    if (start) begin
      busy_d = 1'b1;
      full_d = full;
      row_d  = full ? 5'd0 : start_row;
      col_d  = '0;
    end else if (busy_q) begin
      if (done) begin
        busy_d = 1'b0;
      end else begin
        col_d = col_q + 1'b1;                 // wraps 63 -> 0 on its own
        if (col_q == LAST_COL) row_d = row_q + 1'b1;
      end
    end
  end

  assign addr = make_addr(row_q, col_q);
  assign busy = busy_q;

endmodule

// File: rtl/vga_text_console.sv
// vga_text_console: character-stream terminal front end for the VGA text
// buffer write port.
//   VGA_CLK     : clock (posedge)
//   reset       : asynchronous, active-low; starts a full screen clear
//   ch          : byte stream in (vga_text_console_if.slave)
//   clear       : one-cycle request to clear the whole screen
//   wenable     : text buffer write strobe (one address per cycle)
//   waddr       : {phys_row[4:0], col[5:0]}
//   wdata       : byte to write
//   scroll_base : physical row displayed as logical row 0
//   cursor_col  : logical cursor column
//   cursor_row  : logical cursor row
// Scrolling rotates scroll_base and clears the new bottom row instead of
// moving text. Define VGA_CONSOLE_TAB_EN to make 0x09 advance to the next
// 8-column stop; otherwise 0x09 is ignored like other control bytes.
module vga_text_console #(
  parameter int         ROWS       = vga_console_pkg::ROWS,
  parameter logic [7:0] CLEAR_CHAR = vga_console_pkg::CLEAR_CHAR
) (
  input  logic                VGA_CLK,
  input  logic                reset,
  vga_text_console_if.slave   ch,
  input  logic                clear,
  output logic                wenable,
  output logic [10:0]         waddr,
  output logic [7:0]          wdata,
  output logic [4:0]          scroll_base,
  output logic [5:0]          cursor_col,
  output logic [4:0]          cursor_row
);
  import vga_console_pkg::*;

  localparam logic [5:0] ROWS6    = 6'(ROWS);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);

  console_state_e state_q, state_d;
  logic [5:0]     col_q,   col_d;
  logic [4:0]     row_q,   row_d;
  logic [4:0]     base_q,  base_d;
  logic           pend_q,  pend_d;
  logic           wen_q,   wen_d;
  logic [10:0]    waddr_q, waddr_d;
  logic [7:0]     wdata_q, wdata_d;

  logic           ready, accept;
  logic           newline, start_all;
  logic           fill_start, fill_full, fill_busy, fill_done;
  logic [4:0]     fill_row;
  logic [10:0]    fill_addr;

  assign ready       = (state_q == IDLE) && !clear;
  assign ch.ch_ready = ready;
  assign accept      = ch.ch_valid && ready;

  vga_console_fill #(.ROWS(ROWS)) u_fill (
    .VGA_CLK   (VGA_CLK),
    .reset     (reset),
    .start     (fill_start),
    .start_row (fill_row),
    .full      (fill_full),
    .addr      (fill_addr),
    .busy      (fill_busy),
    .done      (fill_done)
  );

  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      state_q <= CLR_ALL;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      pend_q  <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      pend_q  <= pend_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    base_d     = base_q;
    pend_d     = pend_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    newline    = 1'b0;
    start_all  = 1'b0;
    fill_start = 1'b0;
    fill_full  = 1'b0;
    fill_row   = '0;

    case (state_q)
      IDLE: begin
        if (clear) begin
          start_all = 1'b1;
        end else if (accept) begin
          if ((ch.ch_data >= PRINT_LO) && (ch.ch_data <= PRINT_HI)) begin
            wen_d   = 1'b1;
            waddr_d = make_addr(phys_row(base_q, row_q, ROWS6), col_q);
            wdata_d = ch.ch_data;
            if (col_q == LAST_COL) newline = 1'b1;
            else                   col_d   = col_q + 1'b1;
          end else if (ch.ch_data == ASCII_LF) begin
            newline = 1'b1;
          end else if (ch.ch_data == ASCII_CR) begin
            col_d = '0;
          end else if (ch.ch_data == ASCII_BS) begin
            if (col_q != '0) begin
              col_d   = col_q - 1'b1;
              wen_d   = 1'b1;
              waddr_d = make_addr(phys_row(base_q, row_q, ROWS6), col_q - 1'b1);
              wdata_d = CLEAR_CHAR;
            end
          end
`ifdef VGA_CONSOLE_TAB_EN
          else if (ch.ch_data == ASCII_TAB) begin
            // Columns 56..63 have no further tab stop on this row.
            if (col_q >= 6'd56) newline = 1'b1;
            else                col_d   = {col_q[5:3] + 3'd1, 3'b000};
          end
`endif
        end
      end

      CLR_ROW, CLR_ALL: begin
        wen_d   = fill_busy;
        waddr_d = fill_addr;
        wdata_d = CLEAR_CHAR;
        pend_d  = pend_q | clear;
        // A clear requested during any sweep runs right after it finishes.
        if (fill_done) begin
          if (pend_q || clear) begin
            start_all = 1'b1;
            pend_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (newline) begin
      col_d = '0;
      if (row_q != LAST_ROW) begin
        row_d = row_q + 1'b1;
      end else begin
        // The old top physical row becomes the new bottom row and is blanked.
        base_d     = (base_q == LAST_ROW) ? 5'd0 : base_q + 1'b1;
        state_d    = CLR_ROW;
        fill_start = 1'b1;
        fill_full  = 1'b0;
        fill_row   = phys_row(base_d, LAST_ROW, ROWS6);
      end
    end

    if (start_all) begin
      state_d    = CLR_ALL;
      col_d      = '0;
      row_d      = '0;
      base_d     = '0;
      fill_start = 1'b1;
      fill_full  = 1'b1;
    end
  end

  assign wenable     = wen_q;
  assign waddr       = waddr_q;
  assign wdata       = wdata_q;
  assign scroll_base = base_q;
  assign cursor_col  = col_q;
  assign cursor_row  = row_q;

endmodule
